multiply_acc_feed: RTL and testbench
====================================

# multiply_acc_feed

Stream sequencer that drives the `multiply_acc` datapath from the producer side. It holds a bank of `KER_NUM` kernel coefficients and accepts image pixels over a valid/ready handshake. Each accepted pixel is paired with its kernel coefficient and issued as a `val`/`ma`/`mb` beat. After `KER_NUM` beats it waits for the MAC pipeline to drain, captures the accumulated result and presents it on a valid/ready output, then clears the MAC for the next window.

## Interface
- `IMG_WIDTH`, 16, signed pixel width (drives `ma`)
- `KER_WIDTH`, 8, signed coefficient width (drives `mb`)
- `KER_NUM`, 9, coefficients per window (must be ≥ 2)
- `MAC_LATENCY`, 3, cycles from a `val` beat at the MAC input until it is reflected in `result`
- Derived: RES_WIDTH = IMG_WIDTH+KER_WIDTH+1; AW = clog2(KER_NUM)

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `ker_wr`  in  1  kernel write strobe
- `ker_addr`  in  AW  coefficient index
- `ker_data`  in  KER_WIDTH  coefficient value
- `img_val`  in  1  pixel valid
- `img_data`  in  IMG_WIDTH  pixel
- `img_rdy`  out  1  pixel accepted when `img_val && img_rdy`
- `mac_rst`  out  1  active-high clear to MAC `rst`
- `mac_val`  out  1  MAC beat valid
- `mac_ma`  out  IMG_WIDTH  MAC operand a
- `mac_mb`  out  KER_WIDTH  MAC operand b
- `mac_result`  in  RES_WIDTH  MAC accumulated result
- `res_val`  out  1  window result valid
- `res_data`  out  RES_WIDTH  window result, signed
- `res_rdy`  in  1  result consumed when `res_val && res_rdy`

## Operation
- FSM states: CLR, FEED, DRAIN, HOLD. Reset enters CLR.
- CLR: `mac_rst`=1 for exactly one cycle; `idx`←0; next state is FEED.
- FEED: `img_rdy`=1. Each transfer registers `mac_val`=1, `mac_ma`=`img_data` and `mac_mb`=ker[`idx`], then increments `idx`. On a transfer with `idx`==KER_NUM-1, go to DRAIN. Cycles without a transfer drive `mac_val`=0; `mac_ma`/`mac_mb` hold their values.
- DRAIN: counter loads MAC_LATENCY when the last beat is issued. At 0, `res_data`←`mac_result`, `res_val`←1 and the FSM goes to HOLD.
- HOLD: `res_val` and `res_data` are stable until `res_rdy`. On the handshake, `res_val`←0 and the FSM goes to CLR.
- Kernel bank: a write with `ker_wr` is accepted in any state. `ker_addr` ≥ KER_NUM is ignored. A read and write to the same index in the same cycle returns the old value.
- Arithmetic: this block does no arithmetic on operands. `res_data` is a sign-preserving copy of `mac_result`, except under the configuration below.

## Timing
- Reset values: `img_rdy`=0, `mac_rst`=1, `mac_val`=0, `mac_ma`=0, `mac_mb`=0, `res_val`=0, `res_data`=0; all coefficients 0; `idx`=0.
- Pixel-to-beat latency: 1 cycle (`mac_val` is registered).
- `res_val` rises MAC_LATENCY+1 cycles after the clock edge on which the last `mac_val` beat is driven.
- Window period with no stalls and `res_rdy`=1: KER_NUM + MAC_LATENCY + 3 cycles.
- `img_rdy` is 0 throughout DRAIN, HOLD and CLR. No pixel is accepted outside FEED.
- `img_val` gaps are allowed at any point in FEED. The accumulation result does not depend on gap pattern.
- Reset asserted mid-window abandons the window: no `res_val` is issued for it, and the next window starts from `idx`=0.
- `res_rdy` held high in HOLD: one cycle of `res_val`. `res_rdy` high outside HOLD has no effect.

## Configuration
- `MULTIPLY_ACC_FEED_RELU_EN` defined: the captured result is clamped to 0 if negative (sign bit set); positive values pass unchanged.
- Undefined: `res_data` is the raw signed `mac_result`.

## Structure
- Shared package `multiply_acc_pkg`:
  - FSM state encodings (CLR=0, FEED=1, DRAIN=2, HOLD=3)
  - RES_WIDTH derivation
  - clog2 function
- Sub-module `kernel_bank`: KER_NUM×KER_WIDTH register file with one write port and one combinational read port, reset to zero.

## Test plan
- Kernel all 1, pixels 1..9 continuous, `res_rdy`=1 → one `res_val` pulse with `res_data`=45 exactly MAC_LATENCY+1 cycles after the 9th beat; `mac_rst` pulses once afterwards.
- Kernel all −1, pixels 1..9 → `res_data`=−45 without the macro; `res_data`=0 with `MULTIPLY_ACC_FEED_RELU_EN`.
- Same window as the first scenario with `img_val` toggling every other cycle → `res_data`=45. `mac_val` beats equal accepted pixels exactly (9).
- `res_rdy` low for 10 cycles in HOLD → `res_val` stays 1, `res_data` stays stable, `img_rdy` stays 0. The next window's sum is independent (45 again).
- `rst` asserted after 4 accepted pixels, then a full window of 1..9 → only `res_data`=45 is produced. All outputs are at reset values while `rst` is low.
- Write ker[2]←5 in the same cycle pixel 3 is accepted → that beat uses the old coefficient. The following window uses 5 (sum 45+4·3=57).

Source files
------------

// File: rtl/multiply_acc_pkg.sv
// ---------------------------------------------------------------------------
// multiply_acc_pkg
//
// Shared definitions for the multiply_acc producer-side sequencer:
//   - feed_state_e : sequencer FSM state encoding (CLR/FEED/DRAIN/HOLD)
//   - clog2()      : ceiling log2, usable in parameter expressions
//   - res_width()  : accumulated result width derived from operand widths
//
// No ports (package).
// ---------------------------------------------------------------------------
package multiply_acc_pkg;

    typedef enum logic [1:0] {
        CLR   = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } feed_state_e;

    // Ceiling log2: clog2(1)=0, clog2(2)=1, clog2(9)=4.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    // One guard bit above the full product width so a window of
    // accumulated products keeps its sign.
    function automatic int res_width(input int img_w, input int ker_w);
        return img_w + ker_w + 1;
    endfunction

endpackage

// File: rtl/multiply_acc_feed_kernel_bank.sv
// ---------------------------------------------------------------------------
// kernel_bank
//
// KER_NUM x KER_WIDTH coefficient register file with one synchronous write
// port and one combinational read port. All entries clear to zero on reset.
// A read of the entry being written in the same cycle returns the old value
// because the write only lands on the clock edge.
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-low reset
//   wr_en    in   write strobe
//   wr_addr  in   write index; indices >= KER_NUM are dropped
//   wr_data  in   coefficient to store
//   rd_addr  in   read index
//   rd_data  out  coefficient at rd_addr (zero for out-of-range indices)
// ---------------------------------------------------------------------------
module kernel_bank
    import multiply_acc_pkg::*;
#(
    parameter int KER_WIDTH = 8,
    parameter int KER_NUM   = 9,
    localparam int AW       = clog2(KER_NUM)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [KER_WIDTH-1:0] wr_data,
    input  logic [AW-1:0]        rd_addr,
    output logic [KER_WIDTH-1:0] rd_data
);

    logic [KER_WIDTH-1:0] coef_q [KER_NUM];

    // Address decode compares against each legal index only, so writes to
    // indices past the end of the bank never match and are silently ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < KER_NUM; i++) begin
                coef_q[i] <= '0;
            end
        end else if (wr_en) begin
            for (int i = 0; i < KER_NUM; i++) begin
                if (wr_addr == AW'(i)) begin
                    coef_q[i] <= wr_data;
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < KER_NUM; i++) begin
            if (rd_addr == AW'(i)) begin
                rd_data = coef_q[i];
            end
        end
    end

endmodule

// File: rtl/multiply_acc_feed.sv
// ---------------------------------------------------------------------------
// multiply_acc_feed
//
// Producer-side sequencer for the multiply_acc datapath. Pixels accepted on
// the img_* handshake are paired with the matching kernel coefficient and
// issued as one mac_val/mac_ma/mac_mb beat each. After KER_NUM beats the
// sequencer waits MAC_LATENCY+1 cycles for the MAC pipeline to settle,
// captures mac_result, holds it on res_* until consumed, then pulses mac_rst
// for one cycle to clear the MAC before the next window.
//
// Build option:
//   MULTIPLY_ACC_FEED_RELU_EN  when defined, a negative captured result is
//                              replaced by zero; otherwise the raw signed
//                              mac_result is presented.
//
// Ports:
//   clk         in   clock, rising edge
//   rst         in   asynchronous active-low reset
//   ker_wr      in   coefficient write strobe (accepted in any state)
//   ker_addr    in   coefficient index
//   ker_data    in   coefficient value
//   img_val     in   pixel valid
//   img_data    in   signed pixel
//   img_rdy     out  pixel ready (high only while feeding a window)
//   mac_rst     out  active-high clear to the MAC
//   mac_val     out  MAC beat valid
//   mac_ma      out  MAC operand a (pixel)
//   mac_mb      out  MAC operand b (coefficient)
//   mac_result  in   MAC accumulated result
//   res_val     out  window result valid
//   res_data    out  signed window result
//   res_rdy     in   result consumer ready
// ---------------------------------------------------------------------------
module multiply_acc_feed
    import multiply_acc_pkg::*;
#(
    parameter int IMG_WIDTH   = 16,
    parameter int KER_WIDTH   = 8,
    parameter int KER_NUM     = 9,
    parameter int MAC_LATENCY = 3,
    localparam int RES_WIDTH  = res_width(IMG_WIDTH, KER_WIDTH),
    localparam int AW         = clog2(KER_NUM)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ker_wr,
    input  logic [AW-1:0]        ker_addr,
    input  logic [KER_WIDTH-1:0] ker_data,
    input  logic                 img_val,
    input  logic [IMG_WIDTH-1:0] img_data,
    output logic                 img_rdy,
    output logic                 mac_rst,
    output logic                 mac_val,
    output logic [IMG_WIDTH-1:0] mac_ma,
    output logic [KER_WIDTH-1:0] mac_mb,
    input  logic [RES_WIDTH-1:0] mac_result,
    output logic                 res_val,
    output logic [RES_WIDTH-1:0] res_data,
    input  logic                 res_rdy
);

    // Drain counter must hold MAC_LATENCY; keep at least one bit.
    localparam int CW = (clog2(MAC_LATENCY + 1) < 1) ? 1 : clog2(MAC_LATENCY + 1);

    feed_state_e          state_q;
    logic [AW-1:0]        idx_q;
    logic [CW-1:0]        drain_cnt_q;
    logic                 img_rdy_q;
    logic                 mac_rst_q;
    logic                 mac_val_q;
    logic [IMG_WIDTH-1:0] mac_ma_q;
    logic [KER_WIDTH-1:0] mac_mb_q;
    logic                 res_val_q;
    logic [RES_WIDTH-1:0] res_data_q;

    logic [KER_WIDTH-1:0] ker_rd_data;
    logic [RES_WIDTH-1:0] res_capture_d;
    logic                 img_xfer;

    kernel_bank #(
        .KER_WIDTH (KER_WIDTH),
        .KER_NUM   (KER_NUM)
    ) u_kernel_bank (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (ker_wr),
        .wr_addr (ker_addr),
        .wr_data (ker_data),
        .rd_addr (idx_q),
        .rd_data (ker_rd_data)
    );

    // img_rdy_q is high exactly while in FEED, so this is the whole
    // acceptance condition.
    assign img_xfer = img_val && img_rdy_q;

    // Value captured into res_data when the drain completes.
    always_comb begin
        res_capture_d = mac_result;
`ifdef MULTIPLY_ACC_FEED_RELU_EN
        if (mac_result[RES_WIDTH-1]) begin
            res_capture_d = '0;
        end
`endif
    end

    // Sequencer. Every output is a register updated on the same edge as the
    // state, so img_rdy/mac_rst track FEED/CLR occupancy exactly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= CLR;
            idx_q       <= '0;
            drain_cnt_q <= '0;
            img_rdy_q   <= 1'b0;
            mac_rst_q   <= 1'b1;
            mac_val_q   <= 1'b0;
            mac_ma_q    <= '0;
            mac_mb_q    <= '0;
            res_val_q   <= 1'b0;
            res_data_q  <= '0;
        end else begin
            // Beats are single-cycle; operands hold between beats.
            mac_val_q <= 1'b0;

            case (state_q)
                CLR: begin
                    // mac_rst has been high for this one cycle; release it
                    // and open the pixel port.
                    idx_q     <= '0;
                    mac_rst_q <= 1'b0;
                    img_rdy_q <= 1'b1;
                    state_q   <= FEED;
                end

                FEED: begin
                    if (img_xfer) begin
                        mac_val_q <= 1'b1;
                        mac_ma_q  <= img_data;
                        mac_mb_q  <= ker_rd_data;
                        if (idx_q == AW'(KER_NUM - 1)) begin
                            idx_q       <= '0;
                            img_rdy_q   <= 1'b0;
                            drain_cnt_q <= CW'(MAC_LATENCY);
                            state_q     <= DRAIN;
                        end else begin
                            idx_q <= idx_q + AW'(1);
                        end
                    end
                end

                DRAIN: begin
                    // Loaded on the last beat's edge; capture on the edge
                    // after it reaches zero, i.e. MAC_LATENCY+1 edges later.
                    if (drain_cnt_q == '0) begin
                        res_val_q  <= 1'b1;
                        res_data_q <= res_capture_d;
                        state_q    <= HOLD;
                    end else begin
                        drain_cnt_q <= drain_cnt_q - CW'(1);
                    end
                end

                HOLD: begin
                    if (res_rdy) begin
                        res_val_q <= 1'b0;
                        mac_rst_q <= 1'b1;
                        state_q   <= CLR;
                    end
                end

                default: begin
                    state_q   <= CLR;
                    mac_rst_q <= 1'b1;
                    img_rdy_q <= 1'b0;
                end
            endcase
        end
    end

    assign img_rdy  = img_rdy_q;
    assign mac_rst  = mac_rst_q;
    assign mac_val  = mac_val_q;
    assign mac_ma   = mac_ma_q;
    assign mac_mb   = mac_mb_q;
    assign res_val  = res_val_q;
    assign res_data = res_data_q;

endmodule

// File: tb/tb_multiply_acc_feed.sv
// ---------------------------------------------------------------------------
// tb_multiply_acc_feed
//
// Directed bench for multiply_acc_feed. A small behavioural MAC (accumulator
// plus two delay stages, i.e. a beat is visible in mac_result three cycles
// after it is presented) closes the loop. Expected sums are hand computed.
// ---------------------------------------------------------------------------
module tb_multiply_acc_feed;

    localparam int IMG_WIDTH   = 16;
    localparam int KER_WIDTH   = 8;
    localparam int KER_NUM     = 9;
    localparam int MAC_LATENCY = 3;
    localparam int RES_WIDTH   = 25;
    localparam int AW          = 4;

    localparam logic [RES_WIDTH-1:0] SUM45  = 25'd45;
    localparam logic [RES_WIDTH-1:0] SUM57  = 25'd57;
    localparam logic [RES_WIDTH-1:0] NEG45  = 25'h1FFFFD3;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 ker_wr = 1'b0;
    logic [AW-1:0]        ker_addr = '0;
    logic [KER_WIDTH-1:0] ker_data = '0;
    logic                 img_val = 1'b0;
    logic [IMG_WIDTH-1:0] img_data = '0;
    logic                 img_rdy;
    logic                 mac_rst;
    logic                 mac_val;
    logic [IMG_WIDTH-1:0] mac_ma;
    logic [KER_WIDTH-1:0] mac_mb;
    logic [RES_WIDTH-1:0] mac_result;
    logic                 res_val;
    logic [RES_WIDTH-1:0] res_data;
    logic                 res_rdy = 1'b1;

    always #5 clk = ~clk;

    multiply_acc_feed #(
        .IMG_WIDTH   (IMG_WIDTH),
        .KER_WIDTH   (KER_WIDTH),
        .KER_NUM     (KER_NUM),
        .MAC_LATENCY (MAC_LATENCY)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ker_wr     (ker_wr),
        .ker_addr   (ker_addr),
        .ker_data   (ker_data),
        .img_val    (img_val),
        .img_data   (img_data),
        .img_rdy    (img_rdy),
        .mac_rst    (mac_rst),
        .mac_val    (mac_val),
        .mac_ma     (mac_ma),
        .mac_mb     (mac_mb),
        .mac_result (mac_result),
        .res_val    (res_val),
        .res_data   (res_data),
        .res_rdy    (res_rdy)
    );

    // Behavioural MAC: accumulate on the edge a beat is sampled, then two
    // more register stages before the sum shows on mac_result.
    logic signed [RES_WIDTH-1:0] acc  = '0;
    logic signed [RES_WIDTH-1:0] dly1 = '0;
    logic signed [RES_WIDTH-1:0] dly2 = '0;

    always @(posedge clk) begin
        if (mac_rst) begin
            acc  <= '0;
            dly1 <= '0;
            dly2 <= '0;
        end else begin
            if (mac_val) begin
                acc <= acc + 25'(signed'(mac_ma)) * 25'(signed'(mac_mb));
            end
            dly1 <= acc;
            dly2 <= dly1;
        end
    end
    assign mac_result = dly2;

    // Event monitor.
    int                   cyc            = 0;
    int                   beat_total     = 0;
    int                   last_beat_cyc  = 0;
    int                   res_rise_cyc   = 0;
    int                   res_hs_total   = 0;
    int                   res_val_cycles = 0;
    int                   mac_rst_rises  = 0;
    logic [RES_WIDTH-1:0] res_hs_data    = '0;
    logic                 prev_res_val   = 1'b0;
    logic                 prev_mac_rst   = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mac_val) begin
            beat_total    <= beat_total + 1;
            last_beat_cyc <= cyc;
        end
        if (res_val) res_val_cycles <= res_val_cycles + 1;
        if (res_val && !prev_res_val) res_rise_cyc <= cyc;
        if (res_val && res_rdy) begin
            res_hs_total <= res_hs_total + 1;
            res_hs_data  <= res_data;
        end
        if (mac_rst && !prev_mac_rst) mac_rst_rises <= mac_rst_rises + 1;
        prev_res_val <= res_val;
        prev_mac_rst <= mac_rst;
    end

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_img_rdy"},  32'(img_rdy),  32'd0);
        check({tag, "_mac_rst"},  32'(mac_rst),  32'd1);
        check({tag, "_mac_val"},  32'(mac_val),  32'd0);
        check({tag, "_mac_ma"},   32'(mac_ma),   32'd0);
        check({tag, "_mac_mb"},   32'(mac_mb),   32'd0);
        check({tag, "_res_val"},  32'(res_val),  32'd0);
        check({tag, "_res_data"}, 32'(res_data), 32'd0);
    endtask

    task automatic load_kernel(input logic [KER_WIDTH-1:0] v);
        for (int i = 0; i < KER_NUM; i++) begin
            ker_wr   = 1'b1;
            ker_addr = AW'(i);
            ker_data = v;
            @(negedge clk);
        end
        ker_wr = 1'b0;
    endtask

    task automatic write_coef(input logic [AW-1:0] a, input logic [KER_WIDTH-1:0] v);
        ker_wr   = 1'b1;
        ker_addr = a;
        ker_data = v;
        @(negedge clk);
        ker_wr = 1'b0;
    endtask

    // Offer pixels first..first+n-1; with gaps, one idle cycle precedes
    // each pixel. Returns at the negedge after the last transfer.
    task automatic feed(input int first, input int n, input bit gaps);
        for (int p = first; p < first + n; p++) begin
            if (gaps) begin
                img_val = 1'b0;
                @(negedge clk);
            end
            img_val  = 1'b1;
            img_data = IMG_WIDTH'(p);
            for (int t = 0; t < 40 && !img_rdy; t++) @(negedge clk);
            check("img_rdy_offer", 32'(img_rdy), 32'd1);
            @(negedge clk);
        end
        img_val = 1'b0;
    endtask

    task automatic wait_result(input int hs_before);
        for (int t = 0; t < 60 && res_hs_total == hs_before; t++) @(negedge clk);
        check("result_seen", 32'(res_hs_total - hs_before), 32'd1);
    endtask

    int hs0, b0, rv0, mr0;
    logic [RES_WIDTH-1:0] relu_exp;

    initial begin
        // Reset values while rst is low.
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b1;
        @(negedge clk);

        // Window 1: kernel all 1, pixels 1..9 back to back.
        load_kernel(8'd1);
        hs0 = res_hs_total; b0 = beat_total; rv0 = res_val_cycles; mr0 = mac_rst_rises;
        feed(1, 9, 1'b0);
        check("last_beat_val", 32'(mac_val), 32'd1);
        check("last_beat_ma",  32'(mac_ma),  32'd9);
        check("last_beat_mb",  32'(mac_mb),  32'd1);
        check("drain_img_rdy", 32'(img_rdy), 32'd0);
        wait_result(hs0);
        check("w1_sum",     32'(res_hs_data), 32'(SUM45));
        check("w1_latency", 32'(res_rise_cyc - last_beat_cyc), 32'(MAC_LATENCY + 1));
        check("w1_beats",   32'(beat_total - b0), 32'd9);
        repeat (3) @(negedge clk);
        check("w1_res_val_cycles", 32'(res_val_cycles - rv0), 32'd1);
        check("w1_mac_rst_pulses", 32'(mac_rst_rises - mr0), 32'd1);

        // Window 2: kernel all -1.
        load_kernel(8'hFF);
        hs0 = res_hs_total;
        feed(1, 9, 1'b0);
        check("neg_mb", 32'(mac_mb), 32'hFF);
        wait_result(hs0);
`ifdef MULTIPLY_ACC_FEED_RELU_EN
        relu_exp = '0;
`else
        relu_exp = NEG45;
`endif
        check("neg_sum", 32'(res_hs_data), 32'(relu_exp));

        // Window 3: img_val toggling every other cycle.
        load_kernel(8'd1);
        hs0 = res_hs_total; b0 = beat_total;
        feed(1, 9, 1'b1);
        wait_result(hs0);
        check("gap_sum",   32'(res_hs_data), 32'(SUM45));
        check("gap_beats", 32'(beat_total - b0), 32'd9);

        // Window 4: consumer stalls for 10 cycles in HOLD.
        res_rdy = 1'b0;
        hs0 = res_hs_total;
        feed(1, 9, 1'b0);
        for (int t = 0; t < 20 && !res_val; t++) @(negedge clk);
        check("hold_res_val_up", 32'(res_val), 32'd1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("hold_res_val",  32'(res_val),  32'd1);
            check("hold_res_data", 32'(res_data), 32'(SUM45));
            check("hold_img_rdy",  32'(img_rdy),  32'd0);
        end
        check("hold_no_hs", 32'(res_hs_total - hs0), 32'd0);
        res_rdy = 1'b1;
        wait_result(hs0);
        check("hold_sum", 32'(res_hs_data), 32'(SUM45));
        hs0 = res_hs_total;
        feed(1, 9, 1'b0);
        wait_result(hs0);
        check("after_hold_sum", 32'(res_hs_data), 32'(SUM45));

        // Window 5: reset after 4 pixels abandons the window.
        repeat (2) @(negedge clk);
        hs0 = res_hs_total;
        feed(1, 4, 1'b0);
        rst = 1'b0;
        #1;
        check_reset_vals("midrst");
        repeat (2) @(negedge clk);
        check_reset_vals("midrst_hold");
        rst = 1'b1;
        load_kernel(8'd1);
        feed(1, 9, 1'b0);
        wait_result(hs0);
        check("rst_sum", 32'(res_hs_data), 32'(SUM45));
        repeat (3) @(negedge clk);
        check("rst_one_result", 32'(res_hs_total - hs0), 32'd1);

        // Window 6: ker[2] <- 5 on the cycle pixel 3 is accepted.
        hs0 = res_hs_total;
        feed(1, 2, 1'b0);
        img_val  = 1'b1;
        img_data = 16'd3;
        check("coll_img_rdy", 32'(img_rdy), 32'd1);
        write_coef(4'd2, 8'd5);
        img_val = 1'b0;
        check("coll_ma", 32'(mac_ma), 32'd3);
        check("coll_mb_old", 32'(mac_mb), 32'd1);
        feed(4, 6, 1'b0);
        wait_result(hs0);
        check("coll_sum", 32'(res_hs_data), 32'(SUM45));

        // Out-of-range writes are dropped; next window uses ker[2]=5.
        write_coef(4'd9, 8'h7F);
        write_coef(4'd15, 8'h7F);
        hs0 = res_hs_total;
        feed(1, 3, 1'b0);
        check("new_ma", 32'(mac_ma), 32'd3);
        check("new_mb", 32'(mac_mb), 32'd5);
        feed(4, 6, 1'b0);
        wait_result(hs0);
        check("new_sum", 32'(res_hs_data), 32'(SUM57));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
